// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one shared memory bus, fixed or round-robin tie-break.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 always wins a tie.

module mem_arbiter_port (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        done,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rdata,
    output logic        ack
);
    always_ff @(posedge clock) begin
        if (reset)     rdata <= '0;
        else if (load) rdata <= mem_rdata;
    end

    assign ack = done;
endmodule

module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter bit START_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [14:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic [15:0] p0_rdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [14:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_ack,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        grant_id
);
    localparam int NUM_PORTS = 2;
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                           state, state_nxt;
    logic [3:0]                       cnt;
    req_t                             lat;
    req_t [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0]             req_vld, load_vec, done_vec, ack_vec;
    logic [NUM_PORTS-1:0][15:0]       rdata_vec;
    logic                             grant, win, any_req, rd_load, done;

    assign req_vld = {p1_req, p0_req};
    assign req[0]  = {p0_we, p0_addr, p0_wdata};
    assign req[1]  = {p1_we, p1_addr, p1_wdata};
    assign any_req = |req_vld;

`ifdef MEM_ARB_RR_EN
    // Pointer names the port favoured on the next tie: whoever lost the last grant.
    logic rr_ptr;

    always_ff @(posedge clock) begin
        if (reset)                      rr_ptr <= START_PRIO;
        else if (state == IDLE && any_req) rr_ptr <= ~win;
    end

    assign win = (&req_vld) ? rr_ptr : req_vld[1];
`else
    assign win = ~req_vld[0] & req_vld[1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            grant <= START_PRIO;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                lat   <= req[win];
                grant <= win;
                cnt   <= LAT;
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_load   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (any_req) state_nxt = ACCESS;
            ACCESS: begin
                // Write strobe only on the first access cycle (counter still at full load).
                mem_addr  = {lat.we && (cnt == LAT), 8'd0, lat.addr};
                mem_wdata = lat.wdata;
                if (cnt == 4'd1) begin
                    state_nxt = DONE;
                    rd_load   = ~lat.we;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_port
            assign load_vec[g] = rd_load && (int'(grant) == g);
            assign done_vec[g] = done && (int'(grant) == g);

            mem_arbiter_port u_port (
                .clock     (clock),
                .reset     (reset),
                .load      (load_vec[g]),
                .done      (done_vec[g]),
                .mem_rdata (mem_rdata),
                .rdata     (rdata_vec[g]),
                .ack       (ack_vec[g])
            );
        end
    endgenerate

    assign p0_rdata = rdata_vec[0];
    assign p1_rdata = rdata_vec[1];
    assign p0_ack   = ack_vec[0];
    assign p1_ack   = ack_vec[1];
    assign busy     = (state != IDLE);
    assign grant_id = grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and 3) checked against a
// transaction-timing reference model, plus directed and table-driven sequences.
module tb_mem_arbiter;
    localparam bit START = 1'b0;

    logic        clock, reset;
    logic        p0_req[2], p0_we[2], p1_req[2], p1_we[2];
    logic [14:0] p0_addr[2], p1_addr[2];
    logic [15:0] p0_wdata[2], p1_wdata[2], mem_rdata[2];
    logic [15:0] p0_rdata[2], p1_rdata[2], mem_wdata[2];
    logic        p0_ack[2], p1_ack[2], busy[2], grant_id[2];
    logic [23:0] mem_addr[2];

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    mem_arbiter #(.MEM_LAT(1), .START_PRIO(START)) d1 (
        .clock(clock), .reset(reset),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p0_rdata(p0_rdata[0]), .p0_ack(p0_ack[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .p1_rdata(p1_rdata[0]), .p1_ack(p1_ack[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .grant_id(grant_id[0]));

    mem_arbiter #(.MEM_LAT(3), .START_PRIO(START)) d3 (
        .clock(clock), .reset(reset),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p0_rdata(p0_rdata[1]), .p0_ack(p0_ack[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .p1_rdata(p1_rdata[1]), .p1_ack(p1_ack[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .grant_id(grant_id[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction sampled at edge s occupies the bus for the
    // cycles after edges s..s+L-1, acks after edge s+L, and the next sample can
    // happen no earlier than edge s+L+2.
    int          cyc = 0;
    int          start[2];
    bit          mwe[2], mown[2], mg[2];
    logic [14:0] maddr[2];
    logic [15:0] mwd[2];
    logic [15:0] mrd[2][2];
`ifdef MEM_ARB_RR_EN
    bit          mptr[2];
`endif

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(posedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                start[k] = -1;
                mg[k] = START;
                mrd[k][0] = '0;
                mrd[k][1] = '0;
`ifdef MEM_ARB_RR_EN
                mptr[k] = START;
`endif
            end else begin
                if (start[k] >= 0 && cyc == start[k] + lat_of(k) && !mwe[k])
                    mrd[k][mown[k]] = mem_rdata[k];
                if ((start[k] < 0 || cyc >= start[k] + lat_of(k) + 2) && (p0_req[k] || p1_req[k])) begin
                    bit w;
                    if (p0_req[k] && p1_req[k]) begin
`ifdef MEM_ARB_RR_EN
                        w = mptr[k];
`else
                        w = 1'b0;
`endif
                    end else begin
                        w = p1_req[k];
                    end
`ifdef MEM_ARB_RR_EN
                    mptr[k] = ~w;
`endif
                    mown[k]  = w;
                    mg[k]    = w;
                    mwe[k]   = w ? p1_we[k] : p0_we[k];
                    maddr[k] = w ? p1_addr[k] : p0_addr[k];
                    mwd[k]   = w ? p1_wdata[k] : p0_wdata[k];
                    start[k] = cyc;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit acc, dn;
                logic [23:0] e_addr;
                acc = start[k] >= 0 && cyc >= start[k] && cyc < start[k] + lat_of(k);
                dn  = start[k] >= 0 && cyc == start[k] + lat_of(k);
                e_addr = acc ? {mwe[k] && cyc == start[k], 8'd0, maddr[k]} : 24'd0;
                chk($sformatf("m%0d_busy", k), 32'(busy[k]), 32'(acc || dn));
                chk($sformatf("m%0d_mem_addr", k), 32'(mem_addr[k]), 32'(e_addr));
                chk($sformatf("m%0d_mem_wdata", k), 32'(mem_wdata[k]), acc ? 32'(mwd[k]) : 32'd0);
                chk($sformatf("m%0d_p0_ack", k), 32'(p0_ack[k]), 32'(dn && mown[k] == 1'b0));
                chk($sformatf("m%0d_p1_ack", k), 32'(p1_ack[k]), 32'(dn && mown[k] == 1'b1));
                chk($sformatf("m%0d_grant", k), 32'(grant_id[k]), 32'(mg[k]));
                chk($sformatf("m%0d_p0_rdata", k), 32'(p0_rdata[k]), 32'(mrd[k][0]));
                chk($sformatf("m%0d_p1_rdata", k), 32'(p1_rdata[k]), 32'(mrd[k][1]));
                chk($sformatf("m%0d_ack_onehot", k), 32'(p0_ack[k] & p1_ack[k]), 32'd0);
            end
        end
    end

    task automatic wait_ack(input int k, output bit got);
        got = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clock);
            if (p0_ack[k] || p1_ack[k]) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("d%0d_ack_seen", k), 32'(got), 32'd1);
    endtask

    typedef struct {
        bit r0, r1;
        bit g_rr, g_fx;
    } arb_vec_t;

    arb_vec_t tbl[8];

    initial begin
        bit got, g_exp;
        tbl[0] = '{1, 1, 0, 0};
        tbl[1] = '{1, 1, 1, 0};
        tbl[2] = '{1, 1, 0, 0};
        tbl[3] = '{1, 1, 1, 0};
        tbl[4] = '{0, 1, 1, 1};
        tbl[5] = '{1, 1, 0, 0};
        tbl[6] = '{1, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 0};

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            p0_req[k] = 0; p0_we[k] = 0; p0_addr[k] = '0; p0_wdata[k] = '0;
            p1_req[k] = 0; p1_we[k] = 0; p1_addr[k] = '0; p1_wdata[k] = '0;
            mem_rdata[k] = '0;
        end
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst%0d_mem_addr", k), 32'(mem_addr[k]), 32'd0);
            chk($sformatf("rst%0d_grant", k), 32'(grant_id[k]), 32'(START));
            chk($sformatf("rst%0d_rdata", k), 32'(p0_rdata[k]), 32'd0);
        end
        #1 reset = 1'b0;

        // Single read, MEM_LAT=1
        mem_rdata[0] = 16'hBEEF; p0_we[0] = 0; p0_addr[0] = 15'h2400; p0_req[0] = 1;
        @(negedge clock);
        chk("a_mem_addr", 32'(mem_addr[0]), 32'h002400);
        chk("a_busy", 32'(busy[0]), 32'd1);
        @(negedge clock);
        chk("a_ack", 32'(p0_ack[0]), 32'd1);
        chk("a_rdata", 32'(p0_rdata[0]), 32'hBEEF);
        #1 p0_req[0] = 0;
        @(negedge clock);
        chk("a_ack_low", 32'(p0_ack[0]), 32'd0);
        chk("a_idle", 32'(busy[0]), 32'd0);

        // Single write, MEM_LAT=3
        #1 mem_rdata[1] = 16'hDEAD; p1_we[1] = 1; p1_addr[1] = 15'd5; p1_wdata[1] = 16'h1234; p1_req[1] = 1;
        @(negedge clock);
        chk("b_addr1", 32'(mem_addr[1]), 32'h800005);
        chk("b_wdata", 32'(mem_wdata[1]), 32'h1234);
        @(negedge clock);
        chk("b_addr2", 32'(mem_addr[1]), 32'h000005);
        @(negedge clock);
        chk("b_addr3", 32'(mem_addr[1]), 32'h000005);
        chk("b_noack", 32'(p1_ack[1]), 32'd0);
        @(negedge clock);
        chk("b_ack", 32'(p1_ack[1]), 32'd1);
        chk("b_p0_ack", 32'(p0_ack[1]), 32'd0);
        chk("b_rdata", 32'(p1_rdata[1]), 32'd0);
        #1 p1_req[1] = 0;

        // Arbitration table on MEM_LAT=1, starting from reset
        reset = 1'b1;
        @(negedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p0_req[0] = tbl[i].r0; p1_req[0] = tbl[i].r1;
            p0_we[0] = $urandom_range(0, 1); p1_we[0] = $urandom_range(0, 1);
            p0_addr[0] = 15'($urandom); p1_addr[0] = 15'($urandom);
            mem_rdata[0] = 16'($urandom);
`ifdef MEM_ARB_RR_EN
            g_exp = tbl[i].g_rr;
`else
            g_exp = tbl[i].g_fx;
`endif
            wait_ack(0, got);
            chk($sformatf("tbl%0d_grant", i), 32'(grant_id[0]), 32'(g_exp));
            chk($sformatf("tbl%0d_ack", i), 32'({p1_ack[0], p0_ack[0]}), g_exp ? 32'd2 : 32'd1);
            #1;
        end
        p0_req[0] = 0; p1_req[0] = 0;

        // Reset in the second access cycle of a MEM_LAT=3 write
        p0_we[1] = 1; p0_addr[1] = 15'h0042; p0_wdata[1] = 16'h5555; p0_req[1] = 1;
        @(negedge clock);
        chk("d_addr1", 32'(mem_addr[1]), 32'h800042);
        @(negedge clock);
        chk("d_addr2", 32'(mem_addr[1]), 32'h000042);
        #1 reset = 1'b1; p0_req[1] = 0;
        @(negedge clock);
        chk("d_busy", 32'(busy[1]), 32'd0);
        chk("d_addr", 32'(mem_addr[1]), 32'd0);
        chk("d_ack", 32'(p0_ack[1]), 32'd0);
        #1 reset = 1'b0;
        mem_rdata[1] = 16'hA5C3; p0_we[1] = 0; p0_addr[1] = 15'h0010; p0_req[1] = 1;
        wait_ack(1, got);
        chk("d_rd_ack", 32'(p0_ack[1]), 32'd1);
        chk("d_rdata", 32'(p0_rdata[1]), 32'hA5C3);
        #1 p0_req[1] = 0;
        @(negedge clock);

        // Request dropped and address changed during access
        #1 mem_rdata[1] = 16'h0F0F; p0_we[1] = 0; p0_addr[1] = 15'h0111; p0_req[1] = 1;
        @(negedge clock);
        chk("e_addr1", 32'(mem_addr[1]), 32'h000111);
        #1 p0_req[1] = 0; p0_addr[1] = 15'h7FFF; p0_we[1] = 1;
        @(negedge clock);
        chk("e_addr2", 32'(mem_addr[1]), 32'h000111);
        @(negedge clock);
        chk("e_addr3", 32'(mem_addr[1]), 32'h000111);
        @(negedge clock);
        chk("e_ack", 32'(p0_ack[1]), 32'd1);
        chk("e_rdata", 32'(p0_rdata[1]), 32'h0F0F);
        #1 p0_we[1] = 0;

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            #1;
            reset = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 2; k++) begin
                p0_req[k]    = ($urandom_range(0, 3) != 0);
                p1_req[k]    = ($urandom_range(0, 3) != 0);
                p0_we[k]     = $urandom_range(0, 1);
                p1_we[k]     = $urandom_range(0, 1);
                p0_addr[k]   = 15'($urandom);
                p1_addr[k]   = 15'($urandom);
                p0_wdata[k]  = 16'($urandom);
                p1_wdata[k]  = 16'($urandom);
                mem_rdata[k] = 16'($urandom);
            end
        end
        #1 reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p0_req[k] = 0;
            p1_req[k] = 0;
        end
        repeat (6) @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
